// File: rtl/bvshl_sle_witness_checker_pkg.sv
// bvsle_pkg: shared state encoding, default width and shift helper for the witness checker
package bvsle_pkg;

    typedef enum logic [1:0] {IDLE, CHECK, SWEEP, DONE} state_t;

    localparam int W_DEF = 4;

    // Left shift of a w-bit value; any shift amount of w or more yields zero.
    function automatic logic [7:0] bvshl_w(input logic [7:0] x, input logic [7:0] s, input int w);
        logic [7:0] mask;
        mask = 8'((16'd1 << w) - 16'd1);
        return (int'(s) >= w) ? 8'd0 : ((x << s) & mask);
    endfunction

endpackage

// File: rtl/bvshl_sle_witness_checker_if.sv
// bvshl_sle_witness_checker_if: request/verdict handshake bundle between harness and checker
interface bvshl_sle_witness_checker_if
    import bvsle_pkg::*;
#(
    parameter int W  = W_DEF,
    parameter int CW = 16
);
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_s;
    logic [W-1:0]  in_t;
    logic [W-1:0]  in_x;
    logic          rsp_valid;
    logic          rsp_ready;
    logic          rsp_pass;
    logic          rsp_ic;
    logic [W-1:0]  rsp_witness;
    logic [CW-1:0] fail_count;

    modport master (
        output in_valid, in_s, in_t, in_x, rsp_ready,
        input  in_ready, rsp_valid, rsp_pass, rsp_ic, rsp_witness, fail_count
    );

    modport slave (
        input  in_valid, in_s, in_t, in_x, rsp_ready,
        output in_ready, rsp_valid, rsp_pass, rsp_ic, rsp_witness, fail_count
    );
endinterface

// File: rtl/bvshl_sle_eval.sv
// bvshl_sle_eval: combinational test of (x << s) <=s t at width W
module bvshl_sle_eval
    import bvsle_pkg::*;
#(
    parameter int W = W_DEF
) (
    input  logic [W-1:0] x,
    input  logic [W-1:0] s,
    input  logic [W-1:0] t,
    output logic         sat
);
    logic [W-1:0] sh;

    assign sh  = W'(bvshl_w(8'(x), 8'(s), W));
    assign sat = $signed(sh) <= $signed(t);
endmodule

// File: rtl/bvshl_sle_witness_checker.sv
// bvshl_sle_witness_checker: grades a candidate witness, falling back to an exhaustive sweep over x
module bvshl_sle_witness_checker
    import bvsle_pkg::*;
#(
    parameter int W  = W_DEF,
    parameter int CW = 16
) (
    input  logic clk,
    input  logic rst_n,
    bvshl_sle_witness_checker_if.slave bus
);
    state_t       state, state_nxt;
    logic [W-1:0] s_q, t_q, x_q;
    logic [W:0]   k;
    logic [W-1:0] ex;
    logic         sat;
    logic         last;

    assign ex   = (state == SWEEP) ? k[W-1:0] : x_q;
    assign last = (k == (W+1)'((1 << W) - 1));

    bvshl_sle_eval #(.W(W)) u_eval (
        .x   (ex),
        .s   (s_q),
        .t   (t_q),
        .sat (sat)
    );

    // Next-state selection and the handshake strobes that follow directly from the state
    always_comb begin
        state_nxt     = state;
        bus.in_ready  = 1'b0;
        bus.rsp_valid = 1'b0;
        case (state)
            IDLE: begin
                bus.in_ready = 1'b1;
                state_nxt    = bus.in_valid ? CHECK : IDLE;
            end
            CHECK: state_nxt = sat ? DONE : SWEEP;
            SWEEP: state_nxt = (sat || last) ? DONE : SWEEP;
            DONE: begin
                bus.rsp_valid = 1'b1;
                state_nxt     = bus.rsp_ready ? IDLE : DONE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State register; reset drops any in-flight sweep or pending verdict
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Capture the request operands on acceptance
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s_q <= '0;
            t_q <= '0;
            x_q <= '0;
        end else if (state == IDLE && bus.in_valid) begin
            s_q <= bus.in_s;
            t_q <= bus.in_t;
            x_q <= bus.in_x;
        end
    end

    // Sweep counter: zero outside SWEEP, one extra bit so the final value never wraps
    always_ff @(posedge clk) begin
        if (!rst_n) k <= '0;
        else        k <= (state == SWEEP) ? k + 1'b1 : '0;
    end

    // Verdict registers, written once on the way into DONE and held until consumed
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bus.rsp_pass    <= 1'b0;
            bus.rsp_ic      <= 1'b0;
            bus.rsp_witness <= '0;
        end else if (state == CHECK && sat) begin
            bus.rsp_pass    <= 1'b1;
            bus.rsp_ic      <= 1'b1;
            bus.rsp_witness <= x_q;
        end else if (state == SWEEP && sat) begin
            bus.rsp_pass    <= 1'b0;
            bus.rsp_ic      <= 1'b1;
            bus.rsp_witness <= k[W-1:0];
        end else if (state == SWEEP && last) begin
            bus.rsp_pass    <= 1'b1;
            bus.rsp_ic      <= 1'b0;
            bus.rsp_witness <= '0;
        end
    end

    // Saturating count of consumed failing verdicts
    always_ff @(posedge clk) begin
        if (!rst_n)
            bus.fail_count <= '0;
        else if (state == DONE && bus.rsp_ready && !bus.rsp_pass && bus.fail_count != '1)
            bus.fail_count <= bus.fail_count + 1'b1;
    end
endmodule

// File: tb/tb_bvshl_sle_witness_checker.sv
// tb_bvshl_sle_witness_checker: vector table, random requests against a reference model, and corner sequences
module tb_bvshl_sle_witness_checker;
    localparam int W = 4;
    localparam int N = 1 << W;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   passed = 0;
    int   exp_fail = 0;

    typedef struct {
        int s, t, x, p, ic, wit, lat;
    } vec_t;
    vec_t vecs[9];

    bvshl_sle_witness_checker_if #(.W(W), .CW(16)) bus ();
    bvshl_sle_witness_checker_if #(.W(W), .CW(2))  bus2 ();

    bvshl_sle_witness_checker #(.W(W), .CW(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    bvshl_sle_witness_checker #(.W(W), .CW(2)) dut2 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus2)
    );

    always #5 clk = ~clk;

    function automatic int to_signed(int v);
        return (v >= N / 2) ? v - N : v;
    endfunction

    function automatic bit holds(int x, int s, int t);
        int sh;
        sh = (s >= W) ? 0 : (x << s) % N;
        return to_signed(sh) <= to_signed(t);
    endfunction

    function automatic void model(input int s, input int t, input int x,
                                  output int p, output int ic, output int wit, output int lat);
        if (holds(x, s, t)) begin
            p = 1; ic = 1; wit = x; lat = 2;
        end else begin
            p = 1; ic = 0; wit = 0; lat = N + 2;
            for (int k = N - 1; k >= 0; k--)
                if (holds(k, s, t)) begin
                    p = 0; ic = 1; wit = k; lat = 3 + k;
                end
        end
    endfunction

    task automatic chk(input string name, input int got, input int exp);
        total++;
        if (got == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", name, got, exp);
    endtask

    task automatic send(input int s, input int t, input int x);
        @(negedge clk);
        chk("in_ready_idle", int'(bus.in_ready), 1);
        bus.in_valid = 1'b1;
        bus.in_s = 4'(s);
        bus.in_t = 4'(t);
        bus.in_x = 4'(x);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_valid(output int cyc);
        cyc = 1;
        while (!bus.rsp_valid && cyc < 40) begin
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    task automatic consume(input string name, input int p);
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.rsp_ready = 1'b0;
        if (p == 0) exp_fail++;
        chk({name, ".fail_count"}, int'(bus.fail_count), exp_fail);
        chk({name, ".in_ready_after"}, int'(bus.in_ready), 1);
    endtask

    task automatic run(input string name, input int s, input int t, input int x,
                       input int p, input int ic, input int wit, input int lat);
        int cyc;
        send(s, t, x);
        wait_valid(cyc);
        chk({name, ".latency"}, cyc, lat);
        chk({name, ".pass"}, int'(bus.rsp_pass), p);
        chk({name, ".ic"}, int'(bus.rsp_ic), ic);
        chk({name, ".witness"}, int'(bus.rsp_witness), wit);
        consume(name, p);
    endtask

    initial begin
        int cyc, p, ic, wit, lat, s, t, x;
        bus.in_valid = 1'b0;  bus.rsp_ready = 1'b0;
        bus.in_s = '0; bus.in_t = '0; bus.in_x = '0;
        bus2.in_valid = 1'b0; bus2.rsp_ready = 1'b0;
        bus2.in_s = '0; bus2.in_t = '0; bus2.in_x = '0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst.in_ready", int'(bus.in_ready), 1);
        chk("rst.rsp_valid", int'(bus.rsp_valid), 0);
        chk("rst.rsp_pass", int'(bus.rsp_pass), 0);
        chk("rst.rsp_ic", int'(bus.rsp_ic), 0);
        chk("rst.rsp_witness", int'(bus.rsp_witness), 0);
        chk("rst.fail_count", int'(bus.fail_count), 0);
        rst_n = 1'b1;

        vecs[0] = '{1, 8, 4, 1, 1, 4, 2};
        vecs[1] = '{1, 12, 0, 0, 1, 4, 7};
        vecs[2] = '{5, 15, 3, 1, 0, 0, 18};
        vecs[3] = '{0, 7, 5, 1, 1, 5, 2};
        vecs[4] = '{0, 0, 3, 0, 1, 0, 3};
        vecs[5] = '{3, 0, 1, 1, 1, 1, 2};
        vecs[6] = '{2, 15, 1, 0, 1, 2, 5};
        vecs[7] = '{4, 0, 7, 1, 1, 7, 2};
        vecs[8] = '{0, 8, 9, 0, 1, 8, 11};
        for (int i = 0; i < 9; i++)
            run($sformatf("vec%0d", i), vecs[i].s, vecs[i].t, vecs[i].x,
                vecs[i].p, vecs[i].ic, vecs[i].wit, vecs[i].lat);

        for (int i = 0; i < 40; i++) begin
            s = int'($urandom_range(0, N - 1));
            t = int'($urandom_range(0, N - 1));
            x = int'($urandom_range(0, N - 1));
            model(s, t, x, p, ic, wit, lat);
            run($sformatf("rnd%0d", i), s, t, x, p, ic, wit, lat);
        end

        send(5, 15, 3);
        wait_valid(cyc);
        chk("bp.latency", cyc, 18);
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_s = 4'd1; bus.in_t = 4'h8; bus.in_x = 4'h4;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            chk("bp.hold_valid", int'(bus.rsp_valid), 1);
            chk("bp.hold_pass", int'(bus.rsp_pass), 1);
            chk("bp.hold_ic", int'(bus.rsp_ic), 0);
            chk("bp.hold_witness", int'(bus.rsp_witness), 0);
            chk("bp.hold_in_ready", int'(bus.in_ready), 0);
        end
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.rsp_ready = 1'b0;
        chk("bp.released_in_ready", int'(bus.in_ready), 1);
        chk("bp.released_valid", int'(bus.rsp_valid), 0);
        chk("bp.fail_count", int'(bus.fail_count), exp_fail);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        chk("bp.second_accepted", int'(bus.in_ready), 0);
        wait_valid(cyc);
        chk("bp.second_latency", cyc, 2);
        chk("bp.second_witness", int'(bus.rsp_witness), 4);
        consume("bp.second", 1);

        send(5, 15, 3);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        exp_fail = 0;
        chk("midrst.rsp_valid", int'(bus.rsp_valid), 0);
        chk("midrst.in_ready", int'(bus.in_ready), 1);
        chk("midrst.fail_count", int'(bus.fail_count), 0);
        rst_n = 1'b1;
        run("post_rst", 1, 12, 0, 0, 1, 4, 7);

        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("sat.in_ready", int'(bus2.in_ready), 1);
            bus2.in_valid = 1'b1;
            bus2.in_s = 4'd0; bus2.in_t = 4'd0; bus2.in_x = 4'd3;
            @(posedge clk);
            #1;
            bus2.in_valid = 1'b0;
            cyc = 1;
            while (!bus2.rsp_valid && cyc < 40) begin
                @(posedge clk);
                #1;
                cyc++;
            end
            chk("sat.latency", cyc, 3);
            chk("sat.pass", int'(bus2.rsp_pass), 0);
            bus2.rsp_ready = 1'b1;
            @(posedge clk);
            #1;
            bus2.rsp_ready = 1'b0;
            chk($sformatf("sat.fail_count%0d", i), int'(bus2.fail_count), (i < 3) ? i + 1 : 3);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/bvshl_sle_witness_checker.md
# bvshl_sle_witness_checker

Sequential checker that consumes candidate witnesses for the bit-vector constraint (x << s) <=s t (width W) and grades them. It first evaluates the supplied candidate. If the candidate fails, it sweeps every x value to decide whether any witness exists, which is the invertibility condition. It sits downstream of the generated witness (Skolem) logic in the verification harness and returns one verdict per request over a valid/ready handshake.

## Interface
Parameters:
- W, 4, bit width of s, t, x; 2 ≤ W ≤ 8.
- CW, 16, width of the saturating fail counter.

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- rst_n  in  1  synchronous, active-low reset.
- in_valid  in  1  request valid.
- in_ready  out  1  block can accept a request.
- in_s  in  W  shift amount (unsigned).
- in_t  in  W  bound (two's-complement signed).
- in_x  in  W  candidate witness.
- rsp_valid  out  1  verdict valid.
- rsp_ready  in  1  consumer accepts the verdict.
- rsp_pass  out  1  candidate acceptable.
- rsp_ic  out  1  some x satisfies the constraint.
- rsp_witness  out  W  witness found; equals in_x if the candidate held; 0 if none exists.
- fail_count  out  CW  number of responses delivered with rsp_pass=0; saturates at all-ones.

## Operation
- Evaluation: sh = (s ≥ W) ? 0 : (x << s) truncated to W bits. sat = signed(sh) ≤ signed(t).
- FSM states: IDLE, CHECK, SWEEP, DONE.
- IDLE: in_ready=1. On in_valid & in_ready, latch s, t, x, then go to CHECK.
- CHECK: evaluate the latched x.
  - If sat: rsp_pass=1, rsp_ic=1, rsp_witness=x, go to DONE.
  - Otherwise: clear the sweep counter k to 0 and go to SWEEP.
- SWEEP: evaluate x=k, one value per cycle.
  - On the first sat: rsp_ic=1, rsp_pass=0, rsp_witness=k, go to DONE.
  - If k = 2^W−1 and not sat: rsp_ic=0, rsp_pass=1, rsp_witness=0, go to DONE. An unsatisfiable instance accepts any candidate.
  - Otherwise k increments. The counter is W+1 bits so it cannot wrap silently.
- DONE: rsp_valid=1. All rsp_* outputs stay stable until rsp_ready. On handshake, go to IDLE; if rsp_pass=0, fail_count increments unless saturated.
- in_ready is 0 in every state except IDLE. There is no overlap between requests.
- Reset (any state, including mid-SWEEP or DONE with a pending verdict): state=IDLE, the pending verdict is discarded.
- Reset values: in_ready=1, rsp_valid=0, rsp_pass=0, rsp_ic=0, rsp_witness=0, fail_count=0.

## Timing
- Request accepted on edge 0. CHECK occupies cycle 1.
- Passing candidate: rsp_valid asserts in cycle 2 (latency 2).
- Sweep hit at k: x=k is evaluated in cycle 2+k, and rsp_valid asserts in cycle 3+k.
- No witness: the last evaluation is in cycle 2^W+1, and rsp_valid asserts in cycle 2^W+2 (cycle 18 for W=4).
- rsp_valid=1 with rsp_ready=1 in the same cycle: the response is consumed and in_ready=1 next cycle.
- Request throughput is at most one per 3 cycles.
- in_valid held during DONE is ignored and must remain asserted until the block accepts it.

## Structure
- Shared package bvsle_pkg holds:
  - the state enum (IDLE, CHECK, SWEEP, DONE);
  - the default W;
  - the function bvshl_w(x, s), which implements the s ≥ W zeroing rule.
- One combinational sub-module, bvshl_sle_eval (inputs x, s, t; output sat), is instantiated once. Its x input is muxed between the latched candidate (CHECK) and k (SWEEP).
- The FSM, latches, sweep counter and fail counter all live in the top module.

## Test plan
- W=4, s=1, t=4'h8 (−8), x=4'h4 (x<<1 = −8): rsp_pass=1, rsp_ic=1, rsp_witness=4'h4, rsp_valid in cycle 2.
- s=1, t=4'hC (−4), x=0: sweep hits at k=4 (value −8). rsp_pass=0, rsp_ic=1, rsp_witness=4, rsp_valid in cycle 7, fail_count goes 0→1 on handshake.
- s=5, t=4'hF (−1), x=4'h3: no witness exists since the shift result is always 0. rsp_pass=1, rsp_ic=0, rsp_witness=0, rsp_valid in cycle 18.
- Backpressure: during the previous case, hold rsp_ready=0 for 5 cycles. Outputs stay constant, in_ready=0, and a second in_valid is not accepted until the cycle after the handshake.
- Reset mid-sweep: assert rst_n=0 in cycle 5 of a sweep. Next cycle: rsp_valid=0, in_ready=1, fail_count=0. A new request then completes normally.
- Saturation, with CW=2: deliver 5 failing responses. fail_count reads 1, 2, 3, 3, 3.
